// File: rtl/key_pkg.sv
// Shared types and helpers for the key event scheduler: FSM state encoding,
// default parameters and the round-robin first-set search.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_NUM_KEYS   = 4;
  localparam int DEF_GAP_CYCLES = 1000;
  localparam int MAX_KEYS       = 16;

  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } rr_grant_t;

  // First set bit of pend[num-1:0], scanning ptr, ptr+1, ... and wrapping at num.
  function automatic rr_grant_t rr_first_set(input logic [MAX_KEYS-1:0] pend,
                                             input int unsigned         num,
                                             input int unsigned         ptr);
    rr_grant_t   g;
    int unsigned j;
    g = '0;
    for (int unsigned k = 0; k < MAX_KEYS; k++) begin
      j = ptr + k;
      if (j >= num) j = j - num;
      if (k < num && !g.any && pend[j[3:0]]) begin
        g.any = 1'b1;
        g.idx = j[3:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending key at or after
// the rotating pointer.
module rr_arbiter
  import key_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int IDX_W    = 2
) (
  input  logic [NUM_KEYS-1:0] pending_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                any_o
);

  rr_grant_t grant;

  always_comb begin
    grant = rr_first_set(MAX_KEYS'(pending_i), NUM_KEYS, 32'(ptr_i));
  end

  assign grant_idx_o = IDX_W'(grant.idx);
  assign any_o       = grant.any;

endmodule

// File: rtl/key_event_scheduler.sv
// Queues key presses and issues them one at a time, round-robin, with a
// minimum idle gap. Define KEY_DROP_COUNT_EN to build the dropped-press counter.
module key_event_scheduler
  import key_pkg::*;
#(
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  parameter int IDX_W      = 2,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int DROP_W     = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] key_pulse_i,
  input  logic                enable_i,
  output logic                evt_valid_o,
  output logic [IDX_W-1:0]    evt_idx_o,
  input  logic                evt_ready_i,
  output logic [NUM_KEYS-1:0] pending_o,
  output logic                busy_o,
  output logic [DROP_W-1:0]   drop_count_o
);

  localparam int                CNT_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_KEYS - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                busy_q;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    gap_q, gap_d;

  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;
  logic                handshake;
  logic [NUM_KEYS-1:0] clr_vec;

  rr_arbiter #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .pending_i   (pending_q),
    .ptr_i       (ptr_q),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign handshake = valid_q & evt_ready_i;

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (handshake && idx_q == IDX_W'(i)) clr_vec[i] = 1'b1;
    end
  end

  // A press arriving on the handshake cycle of the same key survives the clear.
  assign pending_d = (pending_q & ~clr_vec) | key_pulse_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i && grant_any) state_d = ISSUE;
      ISSUE:   if (handshake) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (enable_i && grant_any) begin
          valid_d = 1'b1;
          idx_d   = grant_idx;
        end
      end
      ISSUE: begin
        if (handshake) begin
          valid_d = 1'b0;
          ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      busy_q    <= (state_d != IDLE);
      pending_q <= pending_d;
      gap_q     <= gap_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_idx_o   = idx_q;
  assign pending_o   = pending_q;
  assign busy_o      = busy_q;

`ifdef KEY_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_q;
  logic              drop_hit;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign drop_hit = |(key_pulse_i & pending_q & ~clr_vec);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      drop_q <= '0;
    else if (drop_hit) drop_q <= sat_inc(drop_q);
  end

  assign drop_count_o = drop_q;
`else
  assign drop_count_o = DROP_W'(0);
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: stimulus queues expected event
// indices, a negedge monitor pops and compares them on each handshake.
module tb_key_event_scheduler;

  localparam int NK = 4;
  localparam int IW = 2;
  localparam int GAP = 4;
  localparam int DW = 2;
`ifdef KEY_DROP_COUNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_pulse;
  logic          enable;
  logic          evt_valid;
  logic [IW-1:0] evt_idx;
  logic          evt_ready;
  logic [NK-1:0] pending;
  logic          busy;
  logic [DW-1:0] drop_count;

  key_event_scheduler #(
    .NUM_KEYS   (NK),
    .IDX_W      (IW),
    .GAP_CYCLES (GAP),
    .DROP_W     (DW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .key_pulse_i  (key_pulse),
    .enable_i     (enable),
    .evt_valid_o  (evt_valid),
    .evt_idx_o    (evt_idx),
    .evt_ready_i  (evt_ready),
    .pending_o    (pending),
    .busy_o       (busy),
    .drop_count_o (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int mon_pass = 0;
  int mon_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: every accepted event must match the oldest expected index.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      mon_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got idx %0d expected none", evt_idx);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        if (32'(evt_idx) !== e) $display("FAIL event_idx: got %0d expected %0d", evt_idx, e);
        else mon_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [NK-1:0] keys);
    key_pulse = keys;
    tick(1);
    key_pulse = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || evt_valid || pending != '0) && n < 300) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_q.size() == 0 && !busy && !evt_valid && pending == '0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic          v0;
    logic [IW-1:0] i0;
    rst_n = 1'b0;
    key_pulse = '0;
    enable = 1'b0;
    evt_ready = 1'b0;

    // Reset values and idle behaviour
    #2;
    check("rst_valid", evt_valid, 0);
    check("rst_idx", evt_idx, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick(1);
      if (evt_valid) bad++;
    end
    check("idle_no_event", bad, 0);

    // Async reset in the middle of ISSUE abandons the offer
    enable = 1'b1;
    pulse(4'b0010);
    tick(1);
    check("pre_reset_valid", evt_valid, 1);
    check("pre_reset_idx", evt_idx, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_valid", evt_valid, 0);
    check("async_idx", evt_idx, 0);
    check("async_pending", pending, 0);
    check("async_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick(1);
      if (evt_valid) bad++;
    end
    check("no_replay", bad, 0);

    // Single press: latency, pending clear, gap length
    evt_ready = 1'b1;
    exp_q.push_back(2);
    pulse(4'b0100);
    check("single_pending", pending, 4'b0100);
    check("single_not_yet", evt_valid, 0);
    tick(1);
    check("single_valid", evt_valid, 1);
    check("single_idx", evt_idx, 2);
    check("single_busy_issue", busy, 1);
    tick(1);
    check("single_cleared", pending, 0);
    check("single_valid_drop", evt_valid, 0);
    check("gap_busy_0", busy, 1);
    bad = 0;
    repeat (3) begin
      tick(1);
      if (!busy || evt_valid) bad++;
    end
    check("gap_busy_rest", bad, 0);
    tick(1);
    check("gap_end_busy", busy, 0);

    // Round-robin fairness from Ptr=0, then wrap
    reset_dut();
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    pulse(4'b1111);
    wait_drain("rr_all_drain");
    exp_q.push_back(0);
    exp_q.push_back(3);
    pulse(4'b1001);
    wait_drain("rr_wrap_drain");

    // Backpressure with Enable dropped during ISSUE
    evt_ready = 1'b0;
    exp_q.push_back(1);
    pulse(4'b0010);
    tick(1);
    check("bp_valid", evt_valid, 1);
    check("bp_idx", evt_idx, 1);
    v0 = evt_valid;
    i0 = evt_idx;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) enable = 1'b0;
      key_pulse = (i == 8) ? 4'b0100 : 4'b0000;
      tick(1);
      if (evt_valid !== v0 || evt_idx !== i0) bad++;
    end
    key_pulse = '0;
    check("bp_stable", bad, 0);
    check("bp_pending", pending, 4'b0110);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("bp_done_valid", evt_valid, 0);
    check("bp_done_pending", pending, 4'b0100);
    bad = 0;
    repeat (15) begin
      tick(1);
      if (evt_valid) bad++;
    end
    check("bp_no_grant_disabled", bad, 0);
    exp_q.push_back(2);
    evt_ready = 1'b1;
    enable = 1'b1;
    wait_drain("bp_drain");

    // Set-wins collision on the handshake cycle
    exp_q.push_back(1);
    pulse(4'b0010);
    tick(1);
    check("sw_valid", evt_valid, 1);
    check("sw_idx", evt_idx, 1);
    exp_q.push_back(1);
    key_pulse = 4'b0010;
    tick(1);
    key_pulse = '0;
    check("sw_pending_kept", pending, 4'b0010);
    check("sw_valid_drop", evt_valid, 0);
    wait_drain("sw_reissue_drain");

    // Dropped presses with saturating counter
    reset_dut();
    evt_ready = 1'b0;
    repeat (5) pulse(4'b0001);
    check("drop_pending", pending, 4'b0001);
    check("drop_count", drop_count, EXP_DROP);
    check("drop_valid", evt_valid, 1);
    check("drop_idx", evt_idx, 0);
    exp_q.push_back(0);
    evt_ready = 1'b1;
    wait_drain("drop_drain");

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt + mon_pass, total_cnt + mon_total);
    $finish;
  end

endmodule
